skew_feed_bank: RTL and testbench
=================================

// Module: skew_feed_bank
// PURPOSE
//  Parametrised skewed feed buffer for the B-operand edge of the systolic array.
//  Each of DIM columns is a shift chain with its own tap, so an input row leaves
//  staggered by one cycle per column. Adds to the fixed-skew generation:
//  - per-element valid tracking and zero-gated outputs
//  - selectable skew direction
//  - rows-in-flight count, busy flag and done pulse
//  - synchronous flush
// PARAMETERS
//  BITS_AB     8    signed element width
//  DIM         8    column (channel) count, >=2
//  DEPTH_BASE  DIM  delay of the earliest column, in shift edges, >=1
// PORTS
//  clk        in   1                 clock
//  rst_n      in   1                 reset, asynchronous, active-low
//  en         in   1                 shift enable (drain without new data)
//  WrEn       in   1                 push Bin as a new valid row; also shifts
//  clr        in   1                 synchronous flush; dominates en/WrEn
//  mode_i     in   1                 0 = ascending skew, 1 = descending skew
//  Bin        in   BITS_AB x DIM     input row, signed
//  Bout       out  BITS_AB x DIM     skewed outputs, 0 when the column is not valid
//  out_valid  out  DIM               per-column tap valid
//  in_flight  out  $clog2(DEPTH_BASE+DIM)+1   rows pushed, not yet fully emitted
//  busy       out  1                 in_flight != 0
//  done       out  1                 one-cycle pulse, last row fully emitted
// BEHAVIOUR
//  - Reset: all chain data and valids are 0, mode register is 0, and in_flight is 0.
//    All outputs are 0 during reset.
//  - Shift edge: a rising edge with (en|WrEn) && !clr.
//    stage[c][0] <= WrEn ? Bin[c] : 0, valid[c][0] <= WrEn, stage[i] <= stage[i-1].
//  - When there is no shift edge, all state holds and the outputs are stable (stall).
//  - Tap delay d(c), in shift edges:
//    ascending d(c) = DEPTH_BASE+c; descending d(c) = DEPTH_BASE+DIM-1-c.
//    Chain length is DEPTH_BASE+DIM-1. Data beyond the tap is don't-care; valid
//    bits beyond the tap never affect outputs.
//  - Tap timing: a row pushed on shift edge k appears at the column-c tap after
//    shift edge k+d(c)-1. It leaves the tap at the next shift edge.
//  - Bout[c] = out_valid[c] ? stage[c][d(c)-1] : 0. Combinational from registers;
//    no input-to-output path.
//  - Mode register: loads mode_i on every clock edge while busy==0, including the
//    edge that pushes the first row. While busy==1, mode_i is ignored.
//  - Latest column: DIM-1 when ascending, 0 when descending.
//  - in_flight: +1 on a shift edge with WrEn. -1 on a shift edge where the
//    latest-column tap holds a valid element. Both on the same edge: no change.
//    Never wraps: rows in flight never exceed DEPTH_BASE+DIM-1.
//  - done: registered, asserted for the one cycle after an edge where in_flight
//    goes 1->0 through a decrement. Never asserted after clr or reset.
//  - clr: on the edge, all data and valids go to 0, in_flight goes to 0, and done
//    is 0 on the next cycle. The mode register reloads from mode_i.
//    Reset or clr mid-stream discards every partial row.
//  - Back-to-back WrEn every cycle is legal. Rows stream with full throughput
//    and no bubbles.
// CONFIGURATION
//  SKEW_FEED_NOSKEW_EN defined: adds input port noskew (1 bit), latched with the
//    same rule as mode_i. When the latched value is 1, d(c) = DEPTH_BASE for
//    every column, so a row leaves the bank aligned, and the latest column is
//    DIM-1.
//  Macro undefined: the port is absent and behaviour is as if noskew = 0.
// TESTING  (DIM=4, DEPTH_BASE=4, BITS_AB=8 unless noted)
//  1. Reset asserted mid-stream -> Bout, out_valid, in_flight, busy and done all 0
//     immediately, without waiting for a clock edge.
//  2. Ascending: WrEn Bin={1,2,3,4} (col0=1) on edge 1, then en=1 ->
//     Bout[0]=1 after edge 4, Bout[3]=4 after edge 7, in_flight 1->0 at edge 8,
//     done high for one cycle after edge 8.
//  3. Descending: same row -> Bout[3]=4 after edge 4, Bout[0]=1 after edge 7.
//     Each element is valid for exactly one cycle.
//  4. Stream: rows -1..-5 pushed on 5 consecutive edges -> in_flight peaks at 5.
//     Each column emits -1..-5 on consecutive cycles. A single done pulse follows
//     the last row.
//  5. Stall and mode: drop en for 3 cycles mid-stream -> outputs hold. Toggle
//     mode_i while busy -> skew is unchanged.
//  6. clr while in_flight=3 -> all outputs 0 next cycle, in_flight=0, no done.
//     With SKEW_FEED_NOSKEW_EN and noskew=1, all columns emit after edge 4.

Source files
------------

// File: rtl/skew_feed_bank.sv
// Skewed B-operand feed bank: per-column shift chains with a mode-selected tap,
// zero-gated outputs, rows-in-flight tracking and a done pulse.
// Optional aligned (no-skew) mode is enabled by defining SKEW_FEED_NOSKEW_EN.
module skew_feed_bank #(
  parameter int BITS_AB    = 8,
  parameter int DIM        = 8,
  parameter int DEPTH_BASE = DIM
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              WrEn,
  input  logic                              clr,
  input  logic                              mode_i,
`ifdef SKEW_FEED_NOSKEW_EN
  input  logic                              noskew,
`endif
  input  logic [DIM-1:0][BITS_AB-1:0]       Bin,
  output logic [DIM-1:0][BITS_AB-1:0]       Bout,
  output logic [DIM-1:0]                    out_valid,
  output logic [$clog2(DEPTH_BASE+DIM):0]   in_flight,
  output logic                              busy,
  output logic                              done
);

  localparam int CHAIN = DEPTH_BASE + DIM - 1;
  localparam int IDXW  = $clog2(CHAIN);
  localparam int CW    = $clog2(DEPTH_BASE + DIM) + 1;

  logic shift;
  logic inc;
  logic dec;
  logic latest_vld;
  logic mode_reg;
  logic noskew_reg;

  assign shift = (en | WrEn) & ~clr;
  assign busy  = (in_flight != '0);

  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_col
      localparam int ASC = DEPTH_BASE + gi - 1;
      localparam int DSC = DEPTH_BASE + DIM - 2 - gi;
      localparam int ALN = DEPTH_BASE - 1;

      logic [CHAIN-1:0][BITS_AB-1:0] data_reg;
      logic [CHAIN-1:0]              vld_reg;
      logic [IDXW-1:0]               tap;
      logic [CHAIN-2:0]              keep_mask;

      always_comb begin
        if (noskew_reg)
          tap = IDXW'(ALN);
        else if (mode_reg)
          tap = IDXW'(DSC);
        else
          tap = IDXW'(ASC);
      end

      // An element is dropped as it shifts past the tap, so stale valids can
      // never reappear at a different tap after a mode change.
      always_comb begin
        keep_mask = '0;
        for (int i = 0; i < CHAIN - 1; i++)
          keep_mask[i] = (IDXW'(i) < tap);
      end

      assign out_valid[gi] = vld_reg[tap];
      assign Bout[gi]      = vld_reg[tap] ? data_reg[tap] : '0;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
          vld_reg  <= '0;
        end else if (clr) begin
          data_reg <= '0;
          vld_reg  <= '0;
        end else if (shift) begin
          data_reg <= {data_reg[CHAIN-2:0], (WrEn ? Bin[gi] : {BITS_AB{1'b0}})};
          vld_reg  <= {vld_reg[CHAIN-2:0] & keep_mask, WrEn};
        end
      end
    end
  endgenerate

  assign latest_vld = (mode_reg && !noskew_reg) ? out_valid[0] : out_valid[DIM-1];
  assign inc        = shift & WrEn;
  assign dec        = shift & latest_vld;

`ifdef SKEW_FEED_NOSKEW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      noskew_reg <= 1'b0;
    else if (clr || !busy)
      noskew_reg <= noskew;
  end
`else
  assign noskew_reg = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= '0;
      done      <= 1'b0;
      mode_reg  <= 1'b0;
    end else if (clr) begin
      in_flight <= '0;
      done      <= 1'b0;
      mode_reg  <= mode_i;
    end else begin
      if (inc && !dec)
        in_flight <= in_flight + CW'(1);
      else if (dec && !inc)
        in_flight <= in_flight - CW'(1);
      done <= dec && !inc && (in_flight == CW'(1));
      // Skew direction is frozen while any row is in flight.
      if (!busy)
        mode_reg <= mode_i;
    end
  end

endmodule

// File: tb/tb_skew_feed_bank.sv
// Self-checking bench for skew_feed_bank: directed scenarios plus random
// traffic compared against a row-timestamp reference model.
module tb_skew_feed_bank;
  localparam int BITS_AB = 8;
  localparam int DIM     = 4;
  localparam int DB      = 4;
  localparam int CW      = $clog2(DB + DIM) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic WrEn = 1'b0;
  logic clr = 1'b0;
  logic mode_i = 1'b0;
  logic noskew = 1'b0;
  logic [DIM-1:0][BITS_AB-1:0] Bin = '0;
  logic [DIM-1:0][BITS_AB-1:0] Bout;
  logic [DIM-1:0]              out_valid;
  logic [CW-1:0]               in_flight;
  logic                        busy;
  logic                        done;

  always #5 clk = ~clk;

  skew_feed_bank #(.BITS_AB(BITS_AB), .DIM(DIM), .DEPTH_BASE(DB)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn), .clr(clr), .mode_i(mode_i),
`ifdef SKEW_FEED_NOSKEW_EN
    .noskew(noskew),
`endif
    .Bin(Bin), .Bout(Bout), .out_valid(out_valid), .in_flight(in_flight),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  // Reference model: each pushed row remembers the shift-edge count at which it
  // entered; column c shows it while the count equals push + d(c) - 1.
  typedef struct {
    int k;
    logic [DIM-1:0][BITS_AB-1:0] row;
  } row_t;

  row_t rows[$];
  int   s_cnt = 0;
  bit   mode_m = 0;
  bit   noskew_m = 0;
  bit   done_m = 0;

  function automatic int dly(int c);
    if (noskew_m) return DB;
    return mode_m ? (DB + DIM - 1 - c) : (DB + c);
  endfunction

  function automatic int max_dly();
    return noskew_m ? DB : (DB + DIM - 1);
  endfunction

  task automatic model_reset();
    rows.delete();
    s_cnt = 0; mode_m = 0; noskew_m = 0; done_m = 0;
  endtask

  task automatic model_edge();
    int prev;
    prev = rows.size();
    if (clr) begin
      rows.delete();
      s_cnt = 0; mode_m = mode_i; noskew_m = noskew; done_m = 0;
    end else begin
      if (prev == 0) begin
        mode_m = mode_i;
        noskew_m = noskew;
      end
      if (en || WrEn) begin
        s_cnt++;
        if (WrEn) begin
          rows.push_back('{s_cnt, Bin});
          $display("push k=%0d mode=%0d noskew=%0d row=%h", s_cnt, mode_m, noskew_m, Bin);
        end
      end
      while (rows.size() > 0 && s_cnt >= rows[0].k + max_dly()) void'(rows.pop_front());
      done_m = (prev == 1 && rows.size() == 0);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DIM-1:0][BITS_AB-1:0] eb;
    logic [DIM-1:0] ev;
    eb = '0; ev = '0;
    for (int c = 0; c < DIM; c++)
      foreach (rows[r])
        if (s_cnt == rows[r].k + dly(c) - 1) begin
          eb[c] = rows[r].row[c];
          ev[c] = 1'b1;
        end
    chk({tag, "_bout"},   64'(Bout),      64'(eb));
    chk({tag, "_valid"},  64'(out_valid), 64'(ev));
    chk({tag, "_inflt"},  64'(in_flight), 64'(rows.size()));
    chk({tag, "_busy"},   64'(busy),      64'(rows.size() != 0));
    chk({tag, "_done"},   64'(done),      64'(done_m));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst");
    repeat (2) cycle("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_in(input bit e, input bit w, input bit c);
    en = e; WrEn = w; clr = c;
  endtask

  task automatic drain(input int n, input string tag);
    set_in(1, 0, 0);
    repeat (n) cycle(tag);
  endtask

  int peak;
  int dones;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all("init_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Ascending single row
    mode_i = 0;
    for (int c = 0; c < DIM; c++) Bin[c] = 8'(c + 1);
    set_in(0, 1, 0);
    cycle("t2");
    set_in(1, 0, 0);
    for (int e = 2; e <= 9; e++) begin
      cycle("t2");
      if (e == 4) chk("t2_b0_e4", 64'(Bout[0]), 64'd1);
      if (e == 7) chk("t2_b3_e7", 64'(Bout[3]), 64'd4);
      if (e == 8) begin
        chk("t2_done_e8", 64'(done), 64'd1);
        chk("t2_if_e8", 64'(in_flight), 64'd0);
      end
      if (e == 9) chk("t2_done_e9", 64'(done), 64'd0);
    end

    // Descending single row
    mode_i = 1;
    set_in(0, 1, 0);
    cycle("t3");
    set_in(1, 0, 0);
    for (int e = 2; e <= 9; e++) begin
      cycle("t3");
      if (e == 4) chk("t3_b3_e4", 64'(Bout[3]), 64'd4);
      if (e == 5) chk("t3_v3_e5", 64'(out_valid[3]), 64'd0);
      if (e == 7) chk("t3_b0_e7", 64'(Bout[0]), 64'd1);
    end

    // Back-to-back stream of rows -1..-5
    mode_i = 0;
    peak = 0; dones = 0;
    for (int r = 1; r <= 5; r++) begin
      for (int c = 0; c < DIM; c++) Bin[c] = 8'(-r);
      set_in(0, 1, 0);
      cycle("t4");
      if (int'(in_flight) > peak) peak = int'(in_flight);
      if (done) dones++;
    end
    set_in(1, 0, 0);
    repeat (14) begin
      cycle("t4");
      if (int'(in_flight) > peak) peak = int'(in_flight);
      if (done) dones++;
    end
    chk("t4_peak", 64'(peak), 64'd5);
    chk("t4_dones", 64'(dones), 64'd1);

    // Stall with mode toggling while busy
    mode_i = 0;
    for (int r = 0; r < 2; r++) begin
      Bin = 32'(32'h10203040 + r);
      set_in(0, 1, 0);
      cycle("t5");
    end
    drain(2, "t5");
    for (int i = 0; i < 3; i++) begin
      mode_i = ~mode_i;
      set_in(0, 0, 0);
      cycle("t5_stall");
    end
    drain(10, "t5");

    // Flush with three rows in flight
    for (int r = 0; r < 3; r++) begin
      Bin = $urandom;
      set_in(0, 1, 0);
      cycle("t6");
    end
    chk("t6_if3", 64'(in_flight), 64'd3);
    set_in(1, 1, 1);
    cycle("t6_clr");
    chk("t6_if0", 64'(in_flight), 64'd0);
    chk("t6_v0", 64'(out_valid), 64'd0);
    dones = 0;
    drain(10, "t6");
    chk("t6_nodone", 64'(done), 64'd0);

`ifdef SKEW_FEED_NOSKEW_EN
    noskew = 1; mode_i = 0;
    Bin = 32'h0a0b0c0d;
    set_in(0, 1, 0);
    cycle("nsk");
    set_in(1, 0, 0);
    for (int e = 2; e <= 6; e++) begin
      cycle("nsk");
      if (e == 4) chk("nsk_all_e4", 64'(out_valid), 64'hF);
    end
    noskew = 0;
    drain(2, "nsk");
`endif

    // Asynchronous reset mid-stream
    for (int r = 0; r < 5; r++) begin
      Bin = $urandom;
      set_in(1, 1, 0);
      cycle("t1");
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t1_bout", 64'(Bout), 64'd0);
    chk("t1_valid", 64'(out_valid), 64'd0);
    chk("t1_inflt", 64'(in_flight), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 400) == 0) do_reset();
      en     = ($urandom_range(0, 3) != 0);
      WrEn   = $urandom_range(0, 1) == 1;
      clr    = ($urandom_range(0, 60) == 0);
      mode_i = $urandom_range(0, 1) == 1;
`ifdef SKEW_FEED_NOSKEW_EN
      noskew = ($urandom_range(0, 3) == 0);
`endif
      Bin = $urandom;
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
